// File: rtl/ctrl_pkg.sv
// Shared constants and types for the multi-cycle MIPS-subset control unit:
// opcode/funct encodings, ALU codes, FSM states and the datapath control word.
package ctrl_pkg;

  localparam int ALU_CTRL_W_DEF = 3;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [ALU_CTRL_W_DEF-1:0] ALU_NOP = 3'd0;
  localparam logic [ALU_CTRL_W_DEF-1:0] ALU_ADD = 3'd1;
  localparam logic [ALU_CTRL_W_DEF-1:0] ALU_SUB = 3'd2;
  localparam logic [ALU_CTRL_W_DEF-1:0] ALU_AND = 3'd3;
  localparam logic [ALU_CTRL_W_DEF-1:0] ALU_OR  = 3'd4;
  localparam logic [ALU_CTRL_W_DEF-1:0] ALU_SLT = 3'd5;

  localparam logic [1:0] PC_SRC_ALU    = 2'd0;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

  localparam logic [1:0] SRC_B_RT     = 2'd0;
  localparam logic [1:0] SRC_B_FOUR   = 2'd1;
  localparam logic [1:0] SRC_B_IMM    = 2'd2;
  localparam logic [1:0] SRC_B_IMM_SH = 2'd3;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXEC   = 4'd6,
    S_R_WB     = 4'd7,
    S_I_EXEC   = 4'd8,
    S_I_WB     = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_TRAP     = 4'd12
  } state_e;

  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       reg_dst;
    logic       reg_write;
    logic       mem_to_reg;
    logic       instr_done;
    logic       illegal_op;
  } ctrl_t;

endpackage

// File: rtl/alu_decode.sv
// Purpose: map an R-type funct field to an ALU operation and flag unsupported codes.
// Latency: purely combinational, zero cycles.
// Backpressure: none; no handshake.
module alu_decode
  import ctrl_pkg::*;
#(
  parameter int ALU_CTRL_W = ALU_CTRL_W_DEF
) (
  input  logic [5:0]            funct,
  output logic [ALU_CTRL_W-1:0] alu_ctrl,
  output logic                  valid
);

  always_comb begin
    alu_ctrl = '0;
    valid    = 1'b1;
    case (funct)
      FN_ADD:  alu_ctrl = ALU_CTRL_W'(ALU_ADD);
      FN_SUB:  alu_ctrl = ALU_CTRL_W'(ALU_SUB);
      FN_AND:  alu_ctrl = ALU_CTRL_W'(ALU_AND);
      FN_OR:   alu_ctrl = ALU_CTRL_W'(ALU_OR);
      FN_SLT:  alu_ctrl = ALU_CTRL_W'(ALU_SLT);
      default: valid    = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Purpose: multi-cycle FSM sequencing lw/sw/R/addi/beq/j, trapping on unknown encodings.
// Latency: 3-5 cycles per instruction plus one per memory-wait cycle.
// Backpressure: FETCH, MEM_RD and MEM_WR hold mem_req and selects until mem_ready.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int ALU_CTRL_W = ALU_CTRL_W_DEF,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [5:0]            op,
  input  logic [5:0]            funct,
  input  logic                  zero,
  input  logic                  mem_ready,
  output logic                  mem_req,
  output logic                  mem_write,
  output logic                  iord,
  output logic                  ir_write,
  output logic                  pc_write,
  output logic [1:0]            pc_src,
  output logic                  alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic [ALU_CTRL_W-1:0] alu_ctrl,
  output logic                  reg_dst,
  output logic                  reg_write,
  output logic                  mem_to_reg,
  output logic                  instr_done,
  output logic                  illegal_op,
  output logic [CNT_W-1:0]      instr_count
);

  localparam logic [ALU_CTRL_W-1:0] A_ADD = ALU_CTRL_W'(ALU_ADD);
  localparam logic [ALU_CTRL_W-1:0] A_SUB = ALU_CTRL_W'(ALU_SUB);

  state_e                  state;
  state_e                  state_nxt;
  logic                    is_sw;
  ctrl_t                   ctl;
  ctrl_t                   ctl_out;
  logic [ALU_CTRL_W-1:0]   alu_sel;
  logic [ALU_CTRL_W-1:0]   fn_alu;
  logic                    fn_valid;

  alu_decode #(.ALU_CTRL_W(ALU_CTRL_W)) u_alu_decode (
    .funct    (funct),
    .alu_ctrl (fn_alu),
    .valid    (fn_valid)
  );

  // lw/sw choice is latched in DECODE so op is not consulted in MEM_ADDR.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_FETCH;
      is_sw <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_DECODE) is_sw <= (op == OP_SW);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH:    if (mem_ready) state_nxt = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_nxt = S_MEM_ADDR;
          OP_RTYPE:     state_nxt = fn_valid ? S_R_EXEC : S_TRAP;
          OP_ADDI:      state_nxt = S_I_EXEC;
          OP_BEQ:       state_nxt = S_BRANCH;
          OP_J:         state_nxt = S_JUMP;
          default:      state_nxt = S_TRAP;
        endcase
      end
      S_MEM_ADDR: state_nxt = is_sw ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   if (mem_ready) state_nxt = S_MEM_WB;
      S_MEM_WR:   if (mem_ready) state_nxt = S_FETCH;
      S_R_EXEC:   state_nxt = S_R_WB;
      S_I_EXEC:   state_nxt = S_I_WB;
      S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH, S_JUMP: state_nxt = S_FETCH;
      S_TRAP:     state_nxt = S_TRAP;
      default:    state_nxt = S_FETCH;
    endcase
  end

  always_comb begin
    ctl     = '0;
    alu_sel = '0;
    case (state)
      S_FETCH: begin
        ctl.mem_req   = 1'b1;
        ctl.alu_src_b = SRC_B_FOUR;
        ctl.pc_src    = PC_SRC_ALU;
        ctl.ir_write  = mem_ready;
        ctl.pc_write  = mem_ready;
        alu_sel       = A_ADD;
      end
      S_DECODE: begin
        ctl.alu_src_b = SRC_B_IMM_SH;
        alu_sel       = A_ADD;
      end
      S_MEM_ADDR, S_I_EXEC: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = SRC_B_IMM;
        alu_sel       = A_ADD;
      end
      S_MEM_RD: begin
        ctl.mem_req = 1'b1;
        ctl.iord    = 1'b1;
      end
      S_MEM_WB: begin
        ctl.reg_write  = 1'b1;
        ctl.mem_to_reg = 1'b1;
        ctl.instr_done = 1'b1;
      end
      S_MEM_WR: begin
        ctl.mem_req    = 1'b1;
        ctl.mem_write  = 1'b1;
        ctl.iord       = 1'b1;
        ctl.instr_done = mem_ready;
      end
      S_R_EXEC: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = SRC_B_RT;
        alu_sel       = fn_alu;
      end
      S_R_WB: begin
        ctl.reg_write  = 1'b1;
        ctl.reg_dst    = 1'b1;
        ctl.instr_done = 1'b1;
      end
      S_I_WB: begin
        ctl.reg_write  = 1'b1;
        ctl.instr_done = 1'b1;
      end
      S_BRANCH: begin
        ctl.alu_src_a  = 1'b1;
        ctl.alu_src_b  = SRC_B_RT;
        ctl.pc_src     = PC_SRC_ALUOUT;
        ctl.pc_write   = zero;
        ctl.instr_done = 1'b1;
        alu_sel        = A_SUB;
      end
      S_JUMP: begin
        ctl.pc_src     = PC_SRC_JUMP;
        ctl.pc_write   = 1'b1;
        ctl.instr_done = 1'b1;
      end
      S_TRAP:  ctl.illegal_op = 1'b1;
      default: ctl = '0;
    endcase
  end

  // Reset gates the outputs directly so they drop without waiting for an edge.
  assign ctl_out    = reset ? '0 : ctl;
  assign alu_ctrl   = reset ? '0 : alu_sel;
  assign mem_req    = ctl_out.mem_req;
  assign mem_write  = ctl_out.mem_write;
  assign iord       = ctl_out.iord;
  assign ir_write   = ctl_out.ir_write;
  assign pc_write   = ctl_out.pc_write;
  assign pc_src     = ctl_out.pc_src;
  assign alu_src_a  = ctl_out.alu_src_a;
  assign alu_src_b  = ctl_out.alu_src_b;
  assign reg_dst    = ctl_out.reg_dst;
  assign reg_write  = ctl_out.reg_write;
  assign mem_to_reg = ctl_out.mem_to_reg;
  assign instr_done = ctl_out.instr_done;
  assign illegal_op = ctl_out.illegal_op;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_count <= '0;
    end else if (ctl.instr_done) begin
      instr_count <= instr_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench: instruction tasks push the expected control word for each
// cycle; a negedge monitor pops and compares, and tracks the retired count.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] op = '0;
  logic [5:0] funct = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;

  logic        mem_req, mem_write, iord, ir_write, pc_write, alu_src_a;
  logic        reg_dst, reg_write, mem_to_reg, instr_done, illegal_op;
  logic [1:0]  pc_src, alu_src_b;
  logic [2:0]  alu_ctrl;
  logic [31:0] instr_count;

  logic        mem_req_4, mem_write_4, iord_4, ir_write_4, pc_write_4, alu_src_a_4;
  logic        reg_dst_4, reg_write_4, mem_to_reg_4, instr_done_4, illegal_op_4;
  logic [1:0]  pc_src_4, alu_src_b_4;
  logic [2:0]  alu_ctrl_4;
  logic [3:0]  instr_count_4;

  int n_tests = 0;
  int n_fail  = 0;

  logic [17:0] exp_q[$];
  logic [31:0] exp_cnt  = '0;
  logic [3:0]  exp_cnt4 = '0;

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_write(mem_write), .iord(iord), .ir_write(ir_write),
    .pc_write(pc_write), .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_ctrl(alu_ctrl), .reg_dst(reg_dst), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
    .instr_done(instr_done), .illegal_op(illegal_op), .instr_count(instr_count)
  );

  multicycle_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req_4), .mem_write(mem_write_4), .iord(iord_4), .ir_write(ir_write_4),
    .pc_write(pc_write_4), .pc_src(pc_src_4), .alu_src_a(alu_src_a_4), .alu_src_b(alu_src_b_4),
    .alu_ctrl(alu_ctrl_4), .reg_dst(reg_dst_4), .reg_write(reg_write_4), .mem_to_reg(mem_to_reg_4),
    .instr_done(instr_done_4), .illegal_op(illegal_op_4), .instr_count(instr_count_4)
  );

  logic [17:0] obs_w, obs_w4;
  assign obs_w  = {mem_req, mem_write, iord, ir_write, pc_write, pc_src, alu_src_a, alu_src_b,
                   alu_ctrl, reg_dst, reg_write, mem_to_reg, instr_done, illegal_op};
  assign obs_w4 = {mem_req_4, mem_write_4, iord_4, ir_write_4, pc_write_4, pc_src_4, alu_src_a_4,
                   alu_src_b_4, alu_ctrl_4, reg_dst_4, reg_write_4, mem_to_reg_4, instr_done_4,
                   illegal_op_4};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Control word layout: req wr iord irw pcw psrc[2] a b[2] alu[3] rd rw m2r done ill
  function automatic logic [17:0] mk(input logic req, wr, io, irw, pcw, input logic [1:0] psrc,
                                     input logic sa, input logic [1:0] sb, input logic [2:0] alu,
                                     input logic rd, rw, m2r, done, ill);
    return {req, wr, io, irw, pcw, psrc, sa, sb, alu, rd, rw, m2r, done, ill};
  endfunction

  function automatic logic [17:0] w_fetch(input logic r);
    return mk(1, 0, 0, r, r, 2'd0, 0, 2'd1, 3'd1, 0, 0, 0, 0, 0);
  endfunction
  function automatic logic [17:0] w_mwr(input logic r);
    return mk(1, 1, 1, 0, 0, 2'd0, 0, 2'd0, 3'd0, 0, 0, 0, r, 0);
  endfunction
  function automatic logic [17:0] w_rex(input logic [2:0] a);
    return mk(0, 0, 0, 0, 0, 2'd0, 1, 2'd0, a, 0, 0, 0, 0, 0);
  endfunction
  function automatic logic [17:0] w_br(input logic z);
    return mk(0, 0, 0, 0, z, 2'd1, 1, 2'd0, 3'd2, 0, 0, 0, 1, 0);
  endfunction

  localparam logic [17:0] W_DEC  = 18'b0_0_0_0_0_00_0_11_001_0_0_0_0_0;
  localparam logic [17:0] W_ADDR = 18'b0_0_0_0_0_00_1_10_001_0_0_0_0_0;
  localparam logic [17:0] W_MRD  = 18'b1_0_1_0_0_00_0_00_000_0_0_0_0_0;
  localparam logic [17:0] W_MWB  = 18'b0_0_0_0_0_00_0_00_000_0_1_1_1_0;
  localparam logic [17:0] W_RWB  = 18'b0_0_0_0_0_00_0_00_000_1_1_0_1_0;
  localparam logic [17:0] W_IEX  = 18'b0_0_0_0_0_00_1_10_001_0_0_0_0_0;
  localparam logic [17:0] W_IWB  = 18'b0_0_0_0_0_00_0_00_000_0_1_0_1_0;
  localparam logic [17:0] W_JMP  = 18'b0_0_0_0_1_10_0_00_000_0_0_0_1_0;
  localparam logic [17:0] W_TRAP = 18'b0_0_0_0_0_00_0_00_000_0_0_0_0_1;

  always @(negedge clk) begin
    logic [17:0] w;
    if (reset) begin
      exp_cnt  = '0;
      exp_cnt4 = '0;
    end else if (exp_q.size() > 0) begin
      w = exp_q.pop_front();
      check("ctrl", {14'd0, obs_w}, {14'd0, w});
      check("ctrl_cnt4dut", {14'd0, obs_w4}, {14'd0, w});
      check("count", instr_count, exp_cnt);
      check("count4", {28'd0, instr_count_4}, {28'd0, exp_cnt4});
      if (w[1]) begin
        exp_cnt  = exp_cnt + 1;
        exp_cnt4 = exp_cnt4 + 1;
      end
    end
  end

  function automatic logic rnd();
    return $urandom_range(0, 1) != 0;
  endfunction

  task automatic step(input logic rdy, input logic [17:0] w);
    mem_ready = rdy;
    exp_q.push_back(w);
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input int stall);
    repeat (stall) step(1'b0, w_fetch(1'b0));
    step(1'b1, w_fetch(1'b1));
  endtask

  task automatic do_lw(input int stall);
    op = 6'b100011;
    fetch(0); step(rnd(), W_DEC); step(rnd(), W_ADDR);
    repeat (stall) step(1'b0, W_MRD);
    step(1'b1, W_MRD); step(rnd(), W_MWB);
  endtask

  task automatic do_sw(input int stall);
    op = 6'b101011;
    fetch(0); step(rnd(), W_DEC); step(rnd(), W_ADDR);
    repeat (stall) step(1'b0, w_mwr(1'b0));
    step(1'b1, w_mwr(1'b1));
  endtask

  task automatic do_r(input logic [5:0] fn, input logic [2:0] alu);
    op = 6'b000000; funct = fn;
    fetch(0); step(rnd(), W_DEC); step(rnd(), w_rex(alu)); step(rnd(), W_RWB);
  endtask

  task automatic do_beq(input logic z);
    op = 6'b000100; zero = z;
    fetch(0); step(rnd(), W_DEC); step(rnd(), w_br(z));
  endtask

  task automatic do_j();
    op = 6'b000010;
    fetch(0); step(rnd(), W_DEC); step(rnd(), W_JMP);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    #1 reset = 1'b1;
    #2;
    check("rst_async_ctrl", {14'd0, obs_w}, 32'd0);
    check("rst_async_cnt", instr_count, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    mem_ready = 1'b1;
    #1;
    check("rst_hold_ctrl", {14'd0, obs_w}, 32'd0);
    reset = 1'b0;

    do_lw(0);
    do_sw(3);
    do_beq(1'b1);
    do_beq(1'b0);
    do_r(6'b100010, 3'd2);
    do_r(6'b100000, 3'd1);
    do_r(6'b100100, 3'd3);
    do_r(6'b100101, 3'd4);
    do_r(6'b101010, 3'd5);
    op = 6'b001000;
    fetch(2); step(rnd(), W_DEC); step(rnd(), W_IEX); step(rnd(), W_IWB);
    do_lw(2);
    check("count_after_11", instr_count, 32'd11);

    // Unsupported funct: trap persists regardless of mem_ready.
    op = 6'b000000; funct = 6'b000111;
    fetch(0); step(rnd(), W_DEC);
    repeat (10) step(rnd(), W_TRAP);
    check("trap_count", instr_count, 32'd11);
    do_reset();

    // Unsupported opcode also traps.
    op = 6'b111111;
    fetch(0); step(rnd(), W_DEC); step(rnd(), W_TRAP);
    do_reset();

    // Asynchronous reset in the middle of a load read.
    op = 6'b100011;
    fetch(0); step(rnd(), W_DEC); step(rnd(), W_ADDR);
    mem_ready = 1'b0;
    exp_q.push_back(W_MRD);
    @(negedge clk); #1;
    reset = 1'b1;
    #1;
    check("arst_mid_ctrl", {14'd0, obs_w}, 32'd0);
    check("arst_mid_memreq", {31'd0, mem_req}, 32'd0);
    check("arst_mid_cnt", instr_count, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    do_lw(0);

    do_reset();
    repeat (15) do_j();
    check("wrap_pre", {28'd0, instr_count_4}, 32'hF);
    do_j();
    check("wrap_post", {28'd0, instr_count_4}, 32'h0);
    check("nowrap_32", instr_count, 32'd16);

    @(negedge clk); #1;
    check("queue_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
